// File: rtl/mc_mem_unit_if.sv
// Memory request/response bundle between the multicycle control/datapath and mc_mem_unit.
// The master issues byte-addressed read/write requests; the slave answers with a ready pulse.
interface mc_mem_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output addr, wdata, mem_read, mem_write,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mc_mem_unit.sv
// Unified instruction/data memory with a fixed wait-state model and a one-cycle ready pulse.
// Misaligned or read+write requests complete on schedule with err set and no array access.
module mc_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic         clk,
  input  logic         rst,
  mc_mem_unit_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic          rd_reg;
  logic          wr_reg;
  logic          bad_reg;
  logic          ready_reg;
  logic          err_reg;
  logic          rd_valid_reg;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   mem_q;

  logic          in_idle;
  logic          req;
  logic          in_bad;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wdata;
  logic          op_rd;
  logic          op_wr;
  logic          op_bad;
  logic          enter_done;
  logic          do_read;
  logic          do_write;

  assign in_idle = (state_reg == S_IDLE);
  assign req     = bus.mem_read | bus.mem_write;
  assign in_bad  = (bus.addr[1:0] != 2'b00) | (bus.mem_read & bus.mem_write);

  // With zero latency the access happens on the accepting edge, so use the live inputs.
  assign op_idx   = in_idle ? bus.addr[AW+1:2] : idx_reg;
  assign op_wdata = in_idle ? bus.wdata        : wdata_reg;
  assign op_rd    = in_idle ? bus.mem_read     : rd_reg;
  assign op_wr    = in_idle ? bus.mem_write    : wr_reg;
  assign op_bad   = in_idle ? in_bad           : bad_reg;

  assign enter_done = !rst && ((ZERO_LAT && in_idle && req) ||
                               (state_reg == S_WAIT && cnt_reg == 4'd0));
  assign do_read    = enter_done & op_rd & !op_bad;
  assign do_write   = enter_done & op_wr & !op_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      wdata_reg    <= 32'd0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      bad_reg      <= 1'b0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      ready_reg <= enter_done;
      err_reg   <= enter_done & op_bad;
      if (do_read) begin
        rd_valid_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            idx_reg   <= bus.addr[AW+1:2];
            wdata_reg <= bus.wdata;
            rd_reg    <= bus.mem_read;
            wr_reg    <= bus.mem_write;
            bad_reg   <= in_bad;
            cnt_reg   <= CNT_INIT;
            state_reg <= ZERO_LAT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Array kept free of reset so it maps onto block RAM; rdata reads zero until the first read.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[op_idx] <= op_wdata;
    end
    if (do_read) begin
      mem_q <= mem[op_idx];
    end
  end

  assign bus.rdata = rd_valid_reg ? mem_q : 32'd0;
  assign bus.ready = ready_reg;
  assign bus.busy  = !in_idle;
  assign bus.err   = err_reg;

endmodule
